// File: rtl/writeback_pkg.sv
// Shared types for the multi-lane writeback stage: FSM states and the per-lane bundle.
// The retire counter is built only when WB_RETIRE_CNT_EN is defined.
package writeback_pkg;

  localparam int WB_XLEN    = 64;
  localparam int WB_CAUSE_W = 4;
  localparam int LANES_MAX  = 4;

  typedef enum logic {
    WB_RUN,
    WB_TRAP
  } wb_state_e;

  typedef struct packed {
    logic                  valid;
    logic [4:0]            rd;
    logic                  we;
    logic [WB_XLEN-1:0]    data;
    logic                  exc;
    logic [WB_XLEN-1:0]    pc;
    logic [WB_CAUSE_W-1:0] cause;
  } wb_lane_t;

endpackage

// File: rtl/writeback_multi_if.sv
// Lane inputs, regfile write ports and trap signalling of the writeback stage.
// master drives lanes and ack; slave is the writeback stage itself.
interface writeback_multi_if #(
  parameter int XLEN    = 64,
  parameter int LANES   = 2,
  parameter int CAUSE_W = 4
);
  logic                           stall;
  logic                           flush;
  logic [LANES-1:0]               valid_in;
  logic [LANES-1:0][4:0]          rd_in;
  logic [LANES-1:0]               we_in;
  logic [LANES-1:0][XLEN-1:0]     data_in;
  logic [LANES-1:0]               exc_in;
  logic [LANES-1:0][XLEN-1:0]     pc_in;
  logic [LANES-1:0][CAUSE_W-1:0]  cause_in;
  logic                           exception_ack;

  logic [LANES-1:0][4:0]          regfile_rd;
  logic [LANES-1:0][XLEN-1:0]     regfile_wd;
  logic [LANES-1:0]               regfile_we;
  logic                           exception_out;
  logic [XLEN-1:0]                exception_pc_out;
  logic [CAUSE_W-1:0]             exception_cause_out;
  logic                           busy_out;
  logic [63:0]                    retire_count;

  modport master (
    output stall, flush, valid_in, rd_in, we_in, data_in,
    output exc_in, pc_in, cause_in, exception_ack,
    input  regfile_rd, regfile_wd, regfile_we, exception_out,
    input  exception_pc_out, exception_cause_out, busy_out,
    input  retire_count
  );

  modport slave (
    input  stall, flush, valid_in, rd_in, we_in, data_in,
    input  exc_in, pc_in, cause_in, exception_ack,
    output regfile_rd, regfile_wd, regfile_we, exception_out,
    output exception_pc_out, exception_cause_out, busy_out,
    output retire_count
  );
endinterface

// File: rtl/wb_lane_resolve.sv
// Combinational lane arbitration: oldest excepting lane, squash of younger lanes,
// WAW suppression (youngest writer wins) and x0 write masking.
module wb_lane_resolve
  import writeback_pkg::*;
#(
  parameter int LANES = 2
) (
  input  logic [LANES-1:0]      valid,
  input  logic [LANES-1:0]      we,
  input  logic [LANES-1:0]      exc,
  input  logic [LANES-1:0][4:0] rd,
  output logic                  exc_any,
  output logic [LANES-1:0]      exc_sel,
  output logic [LANES-1:0]      retire_mask,
  output logic [LANES-1:0]      we_mask
);

  logic [LANES-1:0] wr;

  always_comb begin
    exc_any     = 1'b0;
    exc_sel     = '0;
    retire_mask = '0;
    wr          = '0;
    we_mask     = '0;
    for (int i = 0; i < LANES; i++) begin
      if (!exc_any) begin
        if (valid[i] && exc[i]) begin
          exc_sel[i] = 1'b1;
          exc_any    = 1'b1;
        end else begin
          retire_mask[i] = valid[i];
        end
      end
      wr[i] = retire_mask[i] & we[i] & (rd[i] != 5'd0);
    end
    // an older writer loses to any younger surviving writer of the same rd
    for (int i = 0; i < LANES; i++) begin
      we_mask[i] = wr[i];
      for (int j = i + 1; j < LANES; j++) begin
        if (wr[j] && rd[j] == rd[i])
          we_mask[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/writeback_multi.sv
// Multi-lane writeback/retire stage with precise traps held until acknowledged.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module writeback_multi
  import writeback_pkg::*;
#(
  parameter int XLEN    = WB_XLEN,
  parameter int LANES   = 2,
  parameter int CAUSE_W = WB_CAUSE_W
) (
  input logic           clk,
  input logic           reset,
  writeback_multi_if.slave bus
);

  wb_state_e                  state;
  wb_lane_t [LANES-1:0]       lane_in;
  logic [LANES-1:0]           valid_v;
  logic [LANES-1:0]           we_v;
  logic [LANES-1:0]           exc_v;
  logic [LANES-1:0][4:0]      rd_v;
  logic [LANES-1:0][4:0]      rd_q;
  logic [LANES-1:0][XLEN-1:0] wd_q;
  logic [LANES-1:0]           we_q;
  logic                       exc_q;
  logic [XLEN-1:0]            pc_q;
  logic [CAUSE_W-1:0]         cause_q;
  logic                       exc_any;
  logic [LANES-1:0]           exc_sel;
  logic [LANES-1:0]           retire_mask;
  logic [LANES-1:0]           we_mask;
  logic [XLEN-1:0]            exc_pc;
  logic [CAUSE_W-1:0]         exc_cause;
  logic                       capture;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_in[i].valid = bus.valid_in[i];
      lane_in[i].rd    = bus.rd_in[i];
      lane_in[i].we    = bus.we_in[i];
      lane_in[i].data  = bus.data_in[i];
      lane_in[i].exc   = bus.exc_in[i];
      lane_in[i].pc    = bus.pc_in[i];
      lane_in[i].cause = bus.cause_in[i];
      valid_v[i]       = lane_in[i].valid;
      we_v[i]          = lane_in[i].we;
      exc_v[i]         = lane_in[i].exc;
      rd_v[i]          = lane_in[i].rd;
    end
  end

  wb_lane_resolve #(.LANES(LANES)) u_resolve (
    .valid       (valid_v),
    .we          (we_v),
    .exc         (exc_v),
    .rd          (rd_v),
    .exc_any     (exc_any),
    .exc_sel     (exc_sel),
    .retire_mask (retire_mask),
    .we_mask     (we_mask)
  );

  always_comb begin
    exc_pc    = '0;
    exc_cause = '0;
    for (int i = 0; i < LANES; i++) begin
      if (exc_sel[i]) begin
        exc_pc    = lane_in[i].pc;
        exc_cause = lane_in[i].cause;
      end
    end
  end

  assign capture = (state == WB_RUN) && !bus.stall && !bus.flush;

  // write enables are one-shot: anything but a fresh capture drops them
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= WB_RUN;
      rd_q    <= '0;
      wd_q    <= '0;
      we_q    <= '0;
      exc_q   <= 1'b0;
      pc_q    <= '0;
      cause_q <= '0;
    end else begin
      we_q <= '0;
      unique case (state)
        WB_RUN: begin
          if (capture) begin
            for (int i = 0; i < LANES; i++) begin
              rd_q[i] <= lane_in[i].rd;
              wd_q[i] <= lane_in[i].data;
            end
            we_q <= we_mask;
            if (exc_any) begin
              state   <= WB_TRAP;
              exc_q   <= 1'b1;
              pc_q    <= exc_pc;
              cause_q <= exc_cause;
            end
          end
        end
        WB_TRAP: begin
          if (bus.exception_ack) begin
            state   <= WB_RUN;
            exc_q   <= 1'b0;
            pc_q    <= '0;
            cause_q <= '0;
          end
        end
        default: state <= WB_RUN;
      endcase
    end
  end

  assign bus.regfile_rd          = rd_q;
  assign bus.regfile_wd          = wd_q;
  assign bus.regfile_we          = we_q;
  assign bus.exception_out       = exc_q;
  assign bus.exception_pc_out    = pc_q;
  assign bus.exception_cause_out = cause_q;
  assign bus.busy_out            = (state == WB_TRAP);

`ifdef WB_RETIRE_CNT_EN
  logic [2:0]  retired;
  logic [63:0] count_q;

  always_comb begin
    retired = '0;
    for (int i = 0; i < LANES; i++)
      retired = retired + {2'b00, retire_mask[i]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count_q <= '0;
    else if (capture)
      count_q <= count_q + 64'(retired);
  end

  assign bus.retire_count = count_q;
`else
  assign bus.retire_count = '0;
`endif

endmodule
